// File: rtl/vga_dither_out_if.sv
// Pixel bus between the timing/image generators and the VGA dither output stage.
// The master drives sync, visibility, position and colour; the slave returns the
// packed TinyVGA Pmod byte plus the delayed sync/visible copies.
interface vga_dither_out_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       visible_in;
  logic [9:0] position_x;
  logic [8:0] position_y;
  logic [3:0] r_in;
  logic [3:0] g_in;
  logic [3:0] b_in;
  logic [7:0] uo_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       visible_out;

  modport master (
    output hsync_in, vsync_in, visible_in, position_x, position_y, r_in, g_in, b_in,
    input  uo_out, hsync_out, vsync_out, visible_out
  );

  modport slave (
    input  hsync_in, vsync_in, visible_in, position_x, position_y, r_in, g_in, b_in,
    output uo_out, hsync_out, vsync_out, visible_out
  );
endinterface

// File: rtl/vga_dither_out.sv
// VGA output stage: 4-bit RGB -> 2-bit RGB with 2x2 Bayer dither, blanking, Pmod packing.
// Latency 2 + EXTRA_DELAY cycles for every signal; no backpressure (one pixel per clock).
// Define TEMPORAL_DITHER_EN to rotate the Bayer threshold once per frame (vsync falling edge).
module vga_dither_out #(
  parameter int EXTRA_DELAY = 0
) (
  input logic        clk,
  input logic        rst,
  vga_dither_out_if.slave bus
);

  // Packed pipeline word: {hsync, vsync, visible, r[1:0], g[1:0], b[1:0]}
  localparam logic [8:0] IDLE_WORD = 9'b1_1_0_00_00_00;

  logic       hs1, vs1, vis1, x1, y1;
  logic [3:0] r1, g1, b1;
  logic [1:0] phase;
  logic [1:0] thr;
  logic [1:0] rq, gq, bq;
  logic [8:0] pipe [0:EXTRA_DELAY];
  logic [8:0] tail;
  logic [1:0] r_o, g_o, b_o;

  // Only the parity of the pixel position selects the Bayer cell.
  logic unused_pos;
  assign unused_pos = ^{bus.position_x[9:1], bus.position_y[8:1]};

  // Stage 1: capture all inputs so the dither math sees a clean registered pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      vis1 <= 1'b0;
      x1   <= 1'b0;
      y1   <= 1'b0;
      r1   <= 4'd0;
      g1   <= 4'd0;
      b1   <= 4'd0;
    end else begin
      hs1  <= bus.hsync_in;
      vs1  <= bus.vsync_in;
      vis1 <= bus.visible_in;
      x1   <= bus.position_x[0];
      y1   <= bus.position_y[0];
      r1   <= bus.r_in;
      g1   <= bus.g_in;
      b1   <= bus.b_in;
    end
  end

`ifdef TEMPORAL_DITHER_EN
  // Edge detection runs on the stage-1 copy of vsync, so the pixel carrying the
  // falling edge is quantised with the old phase and the next pixel gets the new one.
  logic vs_hist;

  // Frame phase: count vsync falling edges modulo 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_hist <= 1'b1;
      phase   <= 2'd0;
    end else begin
      vs_hist <= vs1;
      if (vs_hist && !vs1) begin
        phase <= phase + 2'd1;
      end
    end
  end
`else
  assign phase = 2'd0;
`endif

  function automatic logic [1:0] bayer(input logic y0, input logic x0);
    case ({y0, x0})
      2'b00:   return 2'd0;
      2'b01:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  // Round up when the dropped bits exceed the threshold; never wrap past 3.
  function automatic logic [1:0] quant(input logic [3:0] v, input logic [1:0] t);
    if ((v[1:0] > t) && (v[3:2] != 2'd3)) begin
      return v[3:2] + 2'd1;
    end
    return v[3:2];
  endfunction

  assign thr = bayer(y1, x1) + phase;
  assign rq  = vis1 ? quant(r1, thr) : 2'd0;
  assign gq  = vis1 ? quant(g1, thr) : 2'd0;
  assign bq  = vis1 ? quant(b1, thr) : 2'd0;

  // Stage 2 plus EXTRA_DELAY matching stages; reset flushes every stage at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= EXTRA_DELAY; i++) begin
        pipe[i] <= IDLE_WORD;
      end
    end else begin
      pipe[0] <= {hs1, vs1, vis1, rq, gq, bq};
      for (int i = 1; i <= EXTRA_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[EXTRA_DELAY];
  assign r_o  = tail[5:4];
  assign g_o  = tail[3:2];
  assign b_o  = tail[1:0];

  assign bus.hsync_out   = tail[8];
  assign bus.vsync_out   = tail[7];
  assign bus.visible_out = tail[6];
  assign bus.uo_out      = {tail[8], b_o[0], g_o[0], r_o[0], tail[7], b_o[1], g_o[1], r_o[1]};

endmodule

// File: tb/tb_vga_dither_out.sv
// Randomised and directed bench for vga_dither_out, run on two instances
// (EXTRA_DELAY = 0 and 3) fed identical stimulus and scored against a pixel model.
module tb_vga_dither_out;

  localparam logic [10:0] RST_EXP = {1'b0, 1'b1, 1'b1, 8'b1000_1000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_dither_out_if i0 ();
  vga_dither_out_if i3 ();

  vga_dither_out #(.EXTRA_DELAY(0)) d0 (.clk(clk), .rst(rst), .bus(i0.slave));
  vga_dither_out #(.EXTRA_DELAY(3)) d3 (.clk(clk), .rst(rst), .bus(i3.slave));

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q [$];
  bit          rst_q [$];
  int          ph_cnt  = 0;
  logic        prev_vs = 1'b1;
  string       section = "init";

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s t=%0t got=%b exp=%b", section, tag, $time, got, exp);
    end
  endtask

  // One channel of the ordered dither, straight from the rules.
  function automatic int chan(input int v, input int t, input bit vis);
    int q, e;
    if (!vis) return 0;
    q = v / 4;
    e = v % 4;
    if (e > t && q < 3) return q + 1;
    return q;
  endfunction

  // Expected {visible, hsync, vsync, uo_out} for one input pixel.
  function automatic logic [10:0] model(input bit hs, input bit vs, input bit vis, input bit x0,
                                        input bit y0, input int r, input int g, input int b,
                                        input int ph);
    int bay [4] = '{0, 2, 3, 1};
    int t, ro, go, bo;
    logic [7:0] uo;
    t  = (bay[y0 * 2 + x0] + ph) % 4;
    ro = chan(r, t, vis);
    go = chan(g, t, vis);
    bo = chan(b, t, vis);
    uo = {hs, 1'(bo % 2), 1'(go % 2), 1'(ro % 2), vs, 1'(bo / 2), 1'(go / 2), 1'(ro / 2)};
    return {vis, hs, vs, uo};
  endfunction

  // Output seen after clock n comes from input n-lat unless a reset lies in the window.
  function automatic logic [10:0] expect_at(input int n, input int lat);
    for (int k = n - lat; k < n; k++) begin
      if (k < 0 || rst_q[k]) return RST_EXP;
    end
    return exp_q[n - lat];
  endfunction

  task automatic step(input bit r_st, input bit hs, input bit vs, input bit vis,
                      input logic [9:0] x, input logic [8:0] y,
                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    int ph;
    int n;
    rst = r_st;
    i0.hsync_in = hs;  i0.vsync_in = vs;  i0.visible_in = vis;
    i0.position_x = x; i0.position_y = y; i0.r_in = r; i0.g_in = g; i0.b_in = b;
    i3.hsync_in = hs;  i3.vsync_in = vs;  i3.visible_in = vis;
    i3.position_x = x; i3.position_y = y; i3.r_in = r; i3.g_in = g; i3.b_in = b;
    if (r_st) begin
      ph_cnt  = 0;
      prev_vs = 1'b1;
      exp_q.push_back(RST_EXP);
    end else begin
`ifdef TEMPORAL_DITHER_EN
      ph = ph_cnt % 4;
`else
      ph = 0;
`endif
      exp_q.push_back(model(hs, vs, vis, x[0], y[0], int'(r), int'(g), int'(b), ph));
      if (prev_vs && !vs) ph_cnt++;
      prev_vs = vs;
    end
    rst_q.push_back(r_st);
    @(posedge clk);
    #1;
    n = exp_q.size();
    check("lat2", {i0.visible_out, i0.hsync_out, i0.vsync_out, i0.uo_out}, expect_at(n, 2));
    check("lat5", {i3.visible_out, i3.hsync_out, i3.vsync_out, i3.uo_out}, expect_at(n, 5));
  endtask

  task automatic idle(input int cycles, input bit hs, input bit vs);
    for (int i = 0; i < cycles; i++) step(1'b0, hs, vs, 1'b0, 10'd0, 9'd0, 4'd0, 4'd0, 4'd0);
  endtask

  // Visit all four Bayer cells with the same colour; upper position bits random.
  task automatic cells(input bit vs, input logic [3:0] v);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, vs, 1'b1, {9'($urandom), 1'(c % 2)}, {8'($urandom), 1'(c / 2)}, v, v, v);
    end
  endtask

  initial begin
    logic hs_r, vs_r;
    section = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 10'h3ff, 9'h1ff, 4'hf, 4'hf, 4'hf);

    section = "hsync_latency";
    idle(7, 1'b1, 1'b1);
    idle(4, 1'b0, 1'b1);
    idle(6, 1'b1, 1'b1);

    section = "spatial";
    for (int k = 0; k < 3; k++) cells(1'b1, 4'h6);
    for (int v = 0; v < 16; v++) cells(1'b1, 4'(v));

    section = "saturate_zero";
    cells(1'b1, 4'hf);
    cells(1'b1, 4'h0);

    section = "blanking";
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 4'hf, 4'hf, 4'hf);
    idle(4, 1'b1, 1'b1);

    section = "temporal";
    for (int f = 0; f < 5; f++) begin
      // Visible pixel on the very cycle vsync falls.
      step(1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 9'd0, 4'h6, 4'h6, 4'h6);
      cells(1'b0, 4'h6);
      idle(2, 1'b1, 1'b0);
      cells(1'b1, 4'h6);
      cells(1'b1, 4'h5);
    end

    section = "mid_reset";
    cells(1'b1, 4'h9);
    step(1'b1, 1'b1, 1'b1, 1'b1, 10'd1, 9'd1, 4'h9, 4'h9, 4'h9);
    for (int k = 0; k < 3; k++) cells(1'b1, 4'ha);

    section = "random";
    hs_r = 1'b1;
    vs_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) vs_r = ~vs_r;
      hs_r = ($urandom_range(0, 7) != 0);
      step(($urandom_range(0, 249) == 0), hs_r, vs_r, 1'($urandom),
           10'($urandom), 9'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    section = "drain";
    idle(8, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
